// File: rtl/regfile_2r1w_param_if.sv
// Register file access bundle: decode-side read addresses, writeback-side write
// port, bulk-clear request, and the registered read data / status returned.
interface regfile_2r1w_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              clr_req;
  logic [DATA_W-1:0] q1;
  logic [DATA_W-1:0] q2;
  logic              busy;
  logic              wr_err;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, clr_req,
    input  q1, q2, busy, wr_err
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, clr_req,
    output q1, q2, busy, wr_err
  );
endinterface

// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with registered write-first reads
// and a DEPTH-cycle bulk-clear sequencer. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_2r1w_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                  clk,
  input logic                  reset,
  regfile_2r1w_param_if.slave  bus
);
  localparam int unsigned      DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]  ONE   = (ADDR_W+1)'(1);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q1_r, q2_r;
  logic              wr_err_r;
  logic              wr_ok;
  logic              hit1, hit2;
  logic [DATA_W-1:0] rd1, rd2;

  // Entry 0 is never written in zero-register mode, so it stays at its reset
  // value and folds to a constant; reads and bypass of address 0 yield zero.
  assign wr_ok = (state == IDLE) && bus.we && !(ZERO_REG && (bus.waddr == '0));
  assign hit1  = wr_ok && (bus.waddr == bus.raddr1);
  assign hit2  = wr_ok && (bus.waddr == bus.raddr2);
  assign rd1   = hit1 ? bus.wdata : mem[bus.raddr1];
  assign rd2   = hit2 ? bus.wdata : mem[bus.raddr2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ONE;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else if (state == CLEAR) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_r     <= '0;
      q2_r     <= '0;
      wr_err_r <= 1'b0;
    end else if (state == CLEAR) begin
      q1_r     <= '0;
      q2_r     <= '0;
      wr_err_r <= bus.we;
    end else begin
      q1_r     <= rd1;
      q2_r     <= rd2;
      wr_err_r <= 1'b0;
    end
  end

  assign bus.q1     = q1_r;
  assign bus.q2     = q2_r;
  assign bus.busy   = (state == CLEAR);
  assign bus.wr_err = wr_err_r;
endmodule
